// File: rtl/regfile_rat.sv
`default_nettype none
// ============================================================================
// Module   : regfile_rat
// Brief    : Architectural register file with rename table; 4-wide rename and
//            retire, 8 combinational source read ports with retire forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_rat #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 16,
    parameter int TAG_W    = 4,
    parameter int LANES    = 4,
    parameter int RD_PORTS = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [LANES-1:0]           rename_valid,
    input  logic [LANES*4-1:0]         rename_target,
    input  logic [LANES*TAG_W-1:0]     rename_tag,
    input  logic [LANES-1:0]           retire_valid,
    input  logic [LANES*4-1:0]         retire_target,
    input  logic [LANES*DATA_W-1:0]    retire_data,
    input  logic [LANES*TAG_W-1:0]     retire_tag,
    input  logic [RD_PORTS*4-1:0]      read_reg,
    output logic [RD_PORTS-1:0]        read_busy,
    output logic [RD_PORTS*TAG_W-1:0]  read_tag,
    output logic [RD_PORTS*DATA_W-1:0] read_value,
    output logic [4:0]                 busy_count
);

    localparam int c_IDX_W = 4;
    localparam int c_CNT_W = 5;

    logic [DATA_W-1:0]   r_value [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic [TAG_W-1:0]    r_tag   [NUM_REGS];
    logic [c_CNT_W-1:0]  r_busy_count;

    logic [DATA_W-1:0]   w_value_nxt [NUM_REGS];
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic [TAG_W-1:0]    w_tag_nxt   [NUM_REGS];
    logic [c_CNT_W-1:0]  w_cnt_nxt;

    logic [c_IDX_W-1:0]  w_ren_tgt  [LANES];
    logic [TAG_W-1:0]    w_ren_tag  [LANES];
    logic [c_IDX_W-1:0]  w_ret_tgt  [LANES];
    logic [DATA_W-1:0]   w_ret_data [LANES];
    logic [TAG_W-1:0]    w_ret_tag  [LANES];

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            assign w_ren_tgt[i]  = rename_target[i*c_IDX_W +: c_IDX_W];
            assign w_ren_tag[i]  = rename_tag[i*TAG_W +: TAG_W];
            assign w_ret_tgt[i]  = retire_target[i*c_IDX_W +: c_IDX_W];
            assign w_ret_data[i] = retire_data[i*DATA_W +: DATA_W];
            assign w_ret_tag[i]  = retire_tag[i*TAG_W +: TAG_W];
        end
    endgenerate

    // Lanes are walked in program order so the highest lane wins; renames are
    // applied after retires so a same-cycle rename owns busy and tag.
    always_comb begin
        w_value_nxt = r_value;
        w_busy_nxt  = r_busy;
        w_tag_nxt   = r_tag;
        for (int i = 0; i < LANES; i++) begin
            if (retire_valid[i]) begin
                w_value_nxt[w_ret_tgt[i]] = w_ret_data[i];
                if (r_busy[w_ret_tgt[i]] && (r_tag[w_ret_tgt[i]] == w_ret_tag[i])) begin
                    w_busy_nxt[w_ret_tgt[i]] = 1'b0;
                end
            end
        end
        for (int i = 0; i < LANES; i++) begin
            if (rename_valid[i]) begin
                w_busy_nxt[w_ren_tgt[i]] = 1'b1;
                w_tag_nxt[w_ren_tgt[i]]  = w_ren_tag[i];
            end
        end
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_cnt_nxt = w_cnt_nxt + c_CNT_W'(w_busy_nxt[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_value[r] <= '0;
                r_tag[r]   <= '0;
            end
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            r_value      <= w_value_nxt;
            r_busy       <= w_busy_nxt;
            r_tag        <= w_tag_nxt;
            r_busy_count <= w_cnt_nxt;
        end
    end

    assign busy_count = r_busy_count;

    generate
        for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
            logic [c_IDX_W-1:0] w_idx;
            logic [DATA_W-1:0]  w_val;
            logic               w_hit;

            assign w_idx = read_reg[p*c_IDX_W +: c_IDX_W];

            // Value follows the youngest retiring writer; busy drops only when
            // a retiring writer carries the tag the register is waiting on.
            always_comb begin
                w_val = r_value[w_idx];
                w_hit = 1'b0;
                for (int i = 0; i < LANES; i++) begin
                    if (retire_valid[i] && (w_ret_tgt[i] == w_idx)) begin
                        w_val = w_ret_data[i];
                        if (r_busy[w_idx] && (r_tag[w_idx] == w_ret_tag[i])) begin
                            w_hit = 1'b1;
                        end
                    end
                end
            end

            assign read_busy[p]                  = r_busy[w_idx] & ~w_hit;
            assign read_tag[p*TAG_W +: TAG_W]    = r_tag[w_idx];
            assign read_value[p*DATA_W +: DATA_W] = w_val;
        end
    endgenerate

endmodule
`default_nettype wire
